// File: rtl/calc1_port_driver.sv
// calc1_port_driver
//   Requester-side engine for one calc1 port. Takes a (cmd, op1, op2) transaction
//   from an upstream sequencer over valid/ready. It drives the two-cycle calc1
//   request onto req_cmd_in/req_data_in, then waits for a response or a timeout.
//   The result goes back upstream over valid/ready. A sticky flag records any
//   response that arrives while no request is outstanding.
//
//   Ports
//     c_clk          clock, all state updates on posedge
//     reset          asynchronous active-low reset
//     txn_valid      upstream transaction valid
//     txn_ready      high only while idle
//     txn_cmd        calc1 command (0 = nop; other codes passed through)
//     txn_op1/op2    operands
//     req_cmd_in     registered command to calc1 reqN_cmd_in
//     req_data_in    registered data to calc1 reqN_data_in
//     dut_resp       calc1 out_respN
//     dut_data       calc1 out_dataN
//     rsp_valid      result valid, held until rsp_ready
//     rsp_ready      upstream accepts result
//     rsp_resp       captured response code (00 on nop/timeout)
//     rsp_data       captured data (0 on nop/timeout)
//     rsp_timeout    result was produced by timeout
//     resp_spurious  sticky: non-zero dut_resp seen outside WAIT
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | ready for a transaction; bus driven to zero
//   OP1    | cmd and op1 on the bus
//   OP2    | op2 on the bus, cmd zero
//   WAIT   | bus zero; watching dut_resp, timeout counter running
//   RESP   | result presented upstream until accepted
module calc1_port_driver #(
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter int unsigned CNT_W          = 7    // 2**CNT_W must exceed TIMEOUT_CYCLES
) (
   input  logic        c_clk,
   input  logic        reset,
   input  logic        txn_valid,
   output logic        txn_ready,
   input  logic [3:0]  txn_cmd,
   input  logic [31:0] txn_op1,
   input  logic [31:0] txn_op2,
   output logic [3:0]  req_cmd_in,
   output logic [31:0] req_data_in,
   input  logic [1:0]  dut_resp,
   input  logic [31:0] dut_data,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [1:0]  rsp_resp,
   output logic [31:0] rsp_data,
   output logic        rsp_timeout,
   output logic        resp_spurious
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_OP1  = 3'd1,
      S_OP2  = 3'd2,
      S_WAIT = 3'd3,
      S_RESP = 3'd4
   } state_t;

   // The wait timer counts down from TIMEOUT_CYCLES-1; reaching zero with no
   // response on the bus is the terminal count that produces a timeout.
   localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t            state_q, state_d;
   logic [3:0]        cmd_q, cmd_d;
   logic [31:0]       op2_q, op2_d;
   logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic [3:0]        req_cmd_q, req_cmd_d;
   logic [31:0]       req_data_q, req_data_d;
   logic [1:0]        rsp_resp_q, rsp_resp_d;
   logic [31:0]       rsp_data_q, rsp_data_d;
   logic              rsp_timeout_q, rsp_timeout_d;
   logic              spurious_q, spurious_d;

   always_ff @(posedge c_clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cmd_d         = cmd_q;
      op2_d         = op2_q;
      wait_cnt_d    = wait_cnt_q;
      req_cmd_d     = '0;
      req_data_d    = '0;
      rsp_resp_d    = rsp_resp_q;
      rsp_data_d    = rsp_data_q;
      rsp_timeout_d = rsp_timeout_q;
      spurious_d    = spurious_q;

      unique case (state_q)
         S_IDLE: begin
            if (txn_valid) begin
               state_d    = S_OP1;
               cmd_d      = txn_cmd;
               op2_d      = txn_op2;
               // op1 is loaded straight into the bus register so it appears
               // on the cycle after acceptance.
               req_cmd_d  = txn_cmd;
               req_data_d = txn_op1;
            end
         end
         S_OP1: begin
            state_d    = S_OP2;
            req_data_d = op2_q;
         end
         S_OP2: begin
            if (cmd_q == 4'd0) begin
               // A nop expects no response from calc1.
               state_d       = S_RESP;
               rsp_resp_d    = 2'b00;
               rsp_data_d    = '0;
               rsp_timeout_d = 1'b0;
            end else begin
               state_d    = S_WAIT;
               wait_cnt_d = WAIT_LOAD;
            end
         end
         S_WAIT: begin
            // A response on the terminal-count cycle is checked first, so it
            // wins over the timeout.
            if (dut_resp != 2'b00) begin
               state_d       = S_RESP;
               rsp_resp_d    = dut_resp;
               rsp_data_d    = dut_data;
               rsp_timeout_d = 1'b0;
            end else if (wait_cnt_q == '0) begin
               state_d       = S_RESP;
               rsp_resp_d    = 2'b00;
               rsp_data_d    = '0;
               rsp_timeout_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q - 1'b1;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (state_q != S_WAIT && dut_resp != 2'b00) begin
         spurious_d = 1'b1;
      end
   end

   always_ff @(posedge c_clk or negedge reset) begin
      if (!reset) begin
         cmd_q         <= '0;
         op2_q         <= '0;
         wait_cnt_q    <= '0;
         req_cmd_q     <= '0;
         req_data_q    <= '0;
         rsp_resp_q    <= '0;
         rsp_data_q    <= '0;
         rsp_timeout_q <= 1'b0;
         spurious_q    <= 1'b0;
      end else begin
         cmd_q         <= cmd_d;
         op2_q         <= op2_d;
         wait_cnt_q    <= wait_cnt_d;
         req_cmd_q     <= req_cmd_d;
         req_data_q    <= req_data_d;
         rsp_resp_q    <= rsp_resp_d;
         rsp_data_q    <= rsp_data_d;
         rsp_timeout_q <= rsp_timeout_d;
         spurious_q    <= spurious_d;
      end
   end

   assign txn_ready     = (state_q == S_IDLE);
   assign rsp_valid     = (state_q == S_RESP);
   assign req_cmd_in    = req_cmd_q;
   assign req_data_in   = req_data_q;
   assign rsp_resp      = rsp_resp_q;
   assign rsp_data      = rsp_data_q;
   assign rsp_timeout   = rsp_timeout_q;
   assign resp_spurious = spurious_q;

endmodule

// File: tb/tb_calc1_port_driver.sv
// Bench for calc1_port_driver: table of transactions with expected results,
// scoreboard queue of expected responses, plus hand-written spurious and
// mid-WAIT reset sequences.
module tb_calc1_port_driver;

   localparam int TIMEOUT = 64;
   localparam int BUDGET  = 200;

   logic        c_clk;
   logic        reset;
   logic        txn_valid;
   logic        txn_ready;
   logic [3:0]  txn_cmd;
   logic [31:0] txn_op1;
   logic [31:0] txn_op2;
   logic [3:0]  req_cmd_in;
   logic [31:0] req_data_in;
   logic [1:0]  dut_resp;
   logic [31:0] dut_data;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [1:0]  rsp_resp;
   logic [31:0] rsp_data;
   logic        rsp_timeout;
   logic        resp_spurious;

   calc1_port_driver #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(7)) dut (
      .c_clk        (c_clk),
      .reset        (reset),
      .txn_valid    (txn_valid),
      .txn_ready    (txn_ready),
      .txn_cmd      (txn_cmd),
      .txn_op1      (txn_op1),
      .txn_op2      (txn_op2),
      .req_cmd_in   (req_cmd_in),
      .req_data_in  (req_data_in),
      .dut_resp     (dut_resp),
      .dut_data     (dut_data),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_resp     (rsp_resp),
      .rsp_data     (rsp_data),
      .rsp_timeout  (rsp_timeout),
      .resp_spurious(resp_spurious)
   );

   initial begin
      c_clk = 1'b0;
      forever #5 c_clk = ~c_clk;
   end

   typedef struct {
      logic [3:0]  cmd;
      logic [31:0] op1;
      logic [31:0] op2;
      int          dly;     // WAIT edges with 00 before dut_resp is driven
      logic [1:0]  dresp;   // 00 = calc1 never answers
      logic [31:0] ddata;
      logic [1:0]  eresp;
      logic [31:0] edata;
      logic        eto;
      int          elat;    // edges after op2 phase until rsp_valid is seen
      int          hold;    // cycles of rsp_ready=0 backpressure
   } vec_t;

   typedef struct {
      logic [1:0]  resp;
      logic [31:0] data;
      logic        to;
   } exp_t;

   vec_t vecs[8];
   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge c_clk);
      #1;
   endtask

   task automatic run_txn(input vec_t v);
      exp_t e;
      int   k;
      chk("txn_ready_idle", 32'(txn_ready), 32'd1);
      txn_valid = 1'b1;
      txn_cmd   = v.cmd;
      txn_op1   = v.op1;
      txn_op2   = v.op2;
      sb.push_back('{resp: v.eresp, data: v.edata, to: v.eto});
      tick();                                   // edge N: accepted
      txn_valid = 1'b0;
      txn_cmd   = 4'hX;
      chk("op1_cmd",  32'(req_cmd_in), 32'(v.cmd));
      chk("op1_data", req_data_in, v.op1);
      chk("busy_ready", 32'(txn_ready), 32'd0);
      tick();                                   // edge N+1
      chk("op2_cmd",  32'(req_cmd_in), 32'd0);
      chk("op2_data", req_data_in, v.op2);
      tick();                                   // edge N+2
      chk("bus_idle", {28'd0, req_cmd_in} | req_data_in, 32'd0);
      k = 0;
      if (v.dresp != 2'b00 && v.dly == 0) begin
         dut_resp = v.dresp;
         dut_data = v.ddata;
      end
      while (!rsp_valid && k < BUDGET) begin
         tick();
         k++;
         if (!rsp_valid && v.dresp != 2'b00 && k == v.dly) begin
            dut_resp = v.dresp;
            dut_data = v.ddata;
         end
      end
      dut_resp = 2'b00;
      dut_data = 32'h0;
      chk("latency", 32'(k), 32'(v.elat));
      if (!rsp_valid) begin
         chk("rsp_valid_seen", 32'(rsp_valid), 32'd1);
         void'(sb.pop_front());
         return;
      end
      e = sb.pop_front();
      chk("rsp_resp", 32'(rsp_resp), 32'(e.resp));
      chk("rsp_data", rsp_data, e.data);
      chk("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
      for (int i = 0; i < v.hold; i++) begin
         tick();
         chk("bp_ctrl", {28'd0, rsp_valid, txn_ready, rsp_timeout, 1'b0} | 32'(rsp_resp) << 4,
             {28'd0, 1'b1, 1'b0, e.to, 1'b0} | 32'(e.resp) << 4);
         chk("bp_data", rsp_data, e.data);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("released_valid", 32'(rsp_valid), 32'd0);
      chk("released_ready", 32'(txn_ready), 32'd1);
      chk("held_resp", 32'(rsp_resp), 32'(e.resp));
      chk("held_data", rsp_data, e.data);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      vec_t nopv;

      //        cmd   op1           op2          dly dresp ddata         eresp edata         eto elat hold
      vecs[0] = '{4'd1, 32'd5,        32'd7,       3,  2'b01, 32'd12,       2'b01, 32'd12,       1'b0, 4,   0};
      vecs[1] = '{4'd1, 32'hFFFFFFFF, 32'd1,       0,  2'b10, 32'h0,        2'b10, 32'h0,        1'b0, 1,   0};
      vecs[2] = '{4'd2, 32'd9,        32'd3,       0,  2'b00, 32'h0,        2'b00, 32'h0,        1'b1, 64,  0};
      vecs[3] = '{4'd5, 32'h1234,     32'd4,       1,  2'b01, 32'h12340,    2'b01, 32'h12340,    1'b0, 2,   10};
      vecs[4] = '{4'd0, 32'hAA,       32'hBB,      0,  2'b00, 32'h0,        2'b00, 32'h0,        1'b0, 0,   2};
      vecs[5] = '{4'd6, 32'h80,       32'd1,       63, 2'b11, 32'hDEAD,     2'b11, 32'hDEAD,     1'b0, 64,  0};
      vecs[6] = '{4'd2, 32'd1,        32'd1,       64, 2'b01, 32'h77,       2'b00, 32'h0,        1'b1, 64,  0};
      vecs[7] = '{4'hF, 32'h5A5A,     32'hA5A5,    5,  2'b01, 32'h5555,     2'b01, 32'h5555,     1'b0, 6,   3};

      reset     = 1'b0;
      txn_valid = 1'b0;
      txn_cmd   = 4'd0;
      txn_op1   = 32'd0;
      txn_op2   = 32'd0;
      dut_resp  = 2'b00;
      dut_data  = 32'd0;
      rsp_ready = 1'b0;

      #12;
      chk("rst_txn_ready", 32'(txn_ready), 32'd1);
      chk("rst_req_cmd", 32'(req_cmd_in), 32'd0);
      chk("rst_req_data", req_data_in, 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp", {29'd0, rsp_timeout, rsp_resp}, 32'd0);
      chk("rst_rsp_data", rsp_data, 32'd0);
      chk("rst_spurious", 32'(resp_spurious), 32'd0);
      tick();
      reset = 1'b1;
      tick();

      for (int i = 0; i < 8; i++) begin
         run_txn(vecs[i]);
      end
      chk("no_spurious_yet", 32'(resp_spurious), 32'd0);

      // Response while idle: sticky spurious flag.
      dut_resp = 2'b01;
      tick();
      dut_resp = 2'b00;
      tick();
      chk("spurious_set", 32'(resp_spurious), 32'd1);
      chk("spurious_idle", 32'(txn_ready), 32'd1);
      nopv = '{4'd0, 32'h1, 32'h2, 0, 2'b00, 32'h0, 2'b00, 32'h0, 1'b0, 0, 0};
      run_txn(nopv);
      chk("spurious_sticky", 32'(resp_spurious), 32'd1);

      // Reset asserted mid-WAIT aborts the transaction.
      txn_valid = 1'b1;
      txn_cmd   = 4'd1;
      txn_op1   = 32'h11;
      txn_op2   = 32'h22;
      tick();
      txn_valid = 1'b0;
      repeat (4) tick();
      #2;
      reset = 1'b0;
      #1;
      chk("abort_txn_ready", 32'(txn_ready), 32'd1);
      chk("abort_bus", {28'd0, req_cmd_in} | req_data_in, 32'd0);
      chk("abort_rsp", {28'd0, rsp_valid, rsp_timeout, rsp_resp}, 32'd0);
      chk("abort_rsp_data", rsp_data, 32'd0);
      chk("abort_spurious", 32'(resp_spurious), 32'd0);
      tick();
      reset = 1'b1;
      bad = 0;
      for (int i = 0; i < 80; i++) begin
         tick();
         if (rsp_valid || !txn_ready) bad++;
      end
      chk("abort_no_result", 32'(bad), 32'd0);
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
